fetch_sequencer: RTL and testbench

- Instruction-fetch controller for the processor's program ROM (4-bit instructions, 3-bit address, ROM reads on the falling clock edge when enabled).
- Holds the program counter and drives the ROM enable and address.
- Captures each returned instruction and presents it to the decoder over a valid/ready handshake.
- Supports start, halt, wrap-around at program end, and jumps from the decoder.

---
 rtl/fetch_sequencer.sv | 106 ++++++++++
 tb/tb_fetch_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: walks the program ROM, captures each word and
// hands it to the decoder over a valid/ready handshake, with halt and jump.
module fetch_sequencer #(
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 4,
  parameter int PROG_LEN = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              halt_req,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              rom_enable,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              addr_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    HALT  = 2'd3
  } state_t;

  // Widened bound so PROG_LEN == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   LEN_EXT   = (ADDR_W + 1)'(PROG_LEN);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PROG_LEN - 1);

  state_t            state;
  logic              handshake;
  logic              jump_ok;
  logic [ADDR_W-1:0] pc_next;

  assign rom_addr  = pc;
  assign handshake = instr_valid && instr_ready;
  assign jump_ok   = {1'b0, jump_addr} < LEN_EXT;

  always_comb begin
    pc_next = '0;
    if (jump_en) begin
      if (jump_ok) pc_next = jump_addr;
    end else if (pc != LAST_ADDR) begin
      pc_next = pc + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      rom_enable  <= 1'b0;
      halted      <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      addr_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            pc         <= '0;
            rom_enable <= 1'b1;
            state      <= FETCH;
          end
        end
        FETCH: begin
          instr       <= rom_data;
          instr_valid <= 1'b1;
          rom_enable  <= 1'b0;
          state       <= VALID;
        end
        VALID: begin
          if (handshake) begin
            instr_valid <= 1'b0;
            pc          <= pc_next;
            addr_err    <= jump_en && !jump_ok;
            if (halt_req) begin
              halted <= 1'b1;
              state  <= HALT;
            end else begin
              rom_enable <= 1'b1;
              state      <= FETCH;
            end
          end
        end
        HALT: begin
          // Resume from the held pc rather than restarting the program.
          if (start) begin
            halted     <= 1'b0;
            rom_enable <= 1'b1;
            state      <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: falling-edge ROM model, scoreboard of expected
// instructions, and a table of handshake steps with expected pc/addr_err.
module tb_fetch_sequencer;

  localparam int AW = 3;
  localparam int DW = 4;
  localparam int PL = 7;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          halt_req = 1'b0;
  logic          jump_en = 1'b0;
  logic [AW-1:0] jump_addr = '0;
  logic          rom_enable;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic [DW-1:0] instr;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [AW-1:0] pc;
  logic          halted;
  logic          addr_err;

  fetch_sequencer #(.ADDR_W(AW), .DATA_W(DW), .PROG_LEN(PL)) dut (
    .clock(clock), .reset(reset), .start(start), .halt_req(halt_req),
    .jump_en(jump_en), .jump_addr(jump_addr), .rom_enable(rom_enable),
    .rom_addr(rom_addr), .rom_data(rom_data), .instr(instr),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .pc(pc),
    .halted(halted), .addr_err(addr_err)
  );

  always #5 clock = ~clock;

  logic [DW-1:0] rom_mem [8] = '{4'b1010, 4'b0011, 4'b0111, 4'b0110,
                                 4'b0101, 4'b0100, 4'b0011, 4'b0000};
  logic [DW-1:0] rom_q;
  always @(negedge clock) if (rom_enable) rom_q <= rom_mem[rom_addr];
  assign rom_data = rom_q;

  typedef struct {
    logic          je;
    logic [AW-1:0] ja;
    logic          hr;
    logic [AW-1:0] exp_pc;
    logic          exp_err;
  } row_t;

  row_t          rows [15];
  logic [DW-1:0] exp_q [$];
  logic [AW-1:0] model_pc;
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_valid(output int waits);
    waits = 0;
    while (!instr_valid && waits < 8) begin
      step();
      waits++;
    end
    if (!instr_valid) check("valid_timeout", instr_valid, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
    model_pc = '0;
    check("rst_pc", pc, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_rom_en", rom_enable, 0);
    check("rst_halted", halted, 0);
    check("rst_addr_err", addr_err, 0);
    check("rst_instr", instr, 0);
    check("rst_rom_addr", rom_addr, 0);
  endtask

  task automatic start_fetch();
    start = 1'b1;
    model_pc = '0;
    exp_q.push_back(rom_mem[0]);
    step();
    start = 1'b0;
    check("start_rom_en", rom_enable, 1);
    check("start_pc", pc, 0);
    check("start_valid", instr_valid, 0);
  endtask

  task automatic handshake(input row_t r);
    logic [DW-1:0] e;
    check("addr_err_quiet", addr_err, 0);
    if (exp_q.size() == 0) check("sb_depth", exp_q.size(), 1);
    else begin
      e = exp_q.pop_front();
      check("instr", instr, e);
    end
    instr_ready = 1'b1;
    jump_en     = r.je;
    jump_addr   = r.ja;
    halt_req    = r.hr;
    if (r.je) model_pc = (int'(r.ja) < PL) ? r.ja : '0;
    else      model_pc = (int'(model_pc) == PL - 1) ? '0 : model_pc + 1'b1;
    if (!r.hr) exp_q.push_back(rom_mem[model_pc]);
    step();
    instr_ready = 1'b0;
    jump_en     = 1'b0;
    jump_addr   = '0;
    halt_req    = 1'b0;
    check("hs_pc", pc, r.exp_pc);
    check("hs_addr_err", addr_err, r.exp_err);
    check("hs_valid_drop", instr_valid, 0);
    check("hs_halted", halted, r.hr);
    check("hs_rom_en", rom_enable, !r.hr);
    if (!r.hr) check("hs_rom_addr", rom_addr, r.exp_pc);
  endtask

  task automatic resume();
    for (int unsigned c = 0; c < 4; c++) begin
      check("halt_halted", halted, 1);
      check("halt_rom_en", rom_enable, 0);
      check("halt_pc", pc, model_pc);
      check("halt_valid", instr_valid, 0);
      step();
    end
    start = 1'b1;
    exp_q.push_back(rom_mem[model_pc]);
    step();
    start = 1'b0;
    check("resume_halted", halted, 0);
    check("resume_rom_en", rom_enable, 1);
    check("resume_rom_addr", rom_addr, model_pc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    row_t last;
    rows[0]  = '{1'b0, 3'd0, 1'b0, 3'd1, 1'b0};
    rows[1]  = '{1'b0, 3'd0, 1'b0, 3'd2, 1'b0};
    rows[2]  = '{1'b0, 3'd0, 1'b0, 3'd3, 1'b0};
    rows[3]  = '{1'b0, 3'd0, 1'b0, 3'd4, 1'b0};
    rows[4]  = '{1'b0, 3'd0, 1'b0, 3'd5, 1'b0};
    rows[5]  = '{1'b0, 3'd0, 1'b0, 3'd6, 1'b0};
    rows[6]  = '{1'b0, 3'd0, 1'b0, 3'd0, 1'b0};
    rows[7]  = '{1'b0, 3'd0, 1'b0, 3'd1, 1'b0};
    rows[8]  = '{1'b1, 3'd5, 1'b0, 3'd5, 1'b0};
    rows[9]  = '{1'b1, 3'd7, 1'b0, 3'd0, 1'b1};
    rows[10] = '{1'b0, 3'd0, 1'b0, 3'd1, 1'b0};
    rows[11] = '{1'b0, 3'd0, 1'b0, 3'd2, 1'b0};
    rows[12] = '{1'b0, 3'd0, 1'b1, 3'd3, 1'b0};
    rows[13] = '{1'b1, 3'd4, 1'b1, 3'd4, 1'b0};
    rows[14] = '{1'b0, 3'd0, 1'b0, 3'd5, 1'b0};
    last     = '{1'b0, 3'd0, 1'b0, 3'd1, 1'b0};

    step();
    do_reset();
    start_fetch();
    wait_valid(w);
    check("start_latency", w, 1);

    // Backpressure: first word must sit stable while the decoder stalls.
    for (int unsigned c = 0; c < 5; c++) begin
      check("bp_instr", instr, 4'b1010);
      check("bp_valid", instr_valid, 1);
      check("bp_rom_en", rom_enable, 0);
      check("bp_pc", pc, 0);
      step();
    end

    for (int i = 0; i < 15; i++) begin
      wait_valid(w);
      check("fetch_gap", w, (i == 0) ? 0 : 1);
      handshake(rows[i]);
      if (rows[i].hr) resume();
    end

    wait_valid(w);
    check("pre_reset_valid", instr_valid, 1);
    do_reset();
    start_fetch();
    do_reset();
    start_fetch();
    wait_valid(w);
    check("restart_latency", w, 1);
    handshake(last);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
